// File: rtl/cc_io_bridge.sv
// Port-mapped I/O bridge: decodes the processor port bus, buffers inbound command bytes in an
// RX FIFO, holds one outbound TX byte and raises an acknowledged interrupt.
module cc_io_bridge #(
   parameter int unsigned FIFO_AW      = 3,
   parameter logic [7:0]  PORT_RXDATA  = 8'h00,
   parameter logic [7:0]  PORT_STATUS  = 8'h01,
   parameter logic [7:0]  PORT_TXDATA  = 8'h02,
   parameter logic [7:0]  PORT_IRQEN   = 8'h03,
   parameter logic [7:0]  PORT_RXCOUNT = 8'h04
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] port_id,
   input  logic [7:0] port_out,
   output logic [7:0] port_in,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic       interrupt,
   input  logic       interrupt_ack
);

   localparam int unsigned DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW-1:0] PTR_INC = FIFO_AW'(1);
   localparam logic [FIFO_AW:0]   CNT_INC = (FIFO_AW + 1)'(1);

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               rx_ovf_q, rx_ovf_d;
   logic               tx_drop_q, tx_drop_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic [1:0]         irqen_q, irqen_d;
   logic               interrupt_q, interrupt_d;
   logic [7:0]         port_in_q, port_in_d;

   logic empty, full;
   logic pop, push, ovf_ev;
   logic status_clr;
   logic tx_wr, tx_load, tx_drop_ev, tx_hs;
   logic ev_rx, ev_tx;
   logic [7:0] head;

   // count never exceeds DEPTH, so its MSB alone flags full
   assign empty = (count_q == '0);
   assign full  = count_q[FIFO_AW];
   assign head  = empty ? 8'h00 : mem[rd_ptr_q];

   assign pop        = read_strobe & (port_id == PORT_RXDATA) & ~empty;
   assign push       = rx_valid & (~full | pop);
   assign ovf_ev     = rx_valid & full & ~pop;
   assign status_clr = read_strobe & (port_id == PORT_STATUS);

   assign tx_wr      = write_strobe & (port_id == PORT_TXDATA);
   assign tx_load    = tx_wr & ~tx_valid_q;
   assign tx_drop_ev = tx_wr & tx_valid_q;
   assign tx_hs      = tx_valid_q & tx_ready;

   assign ev_rx = irqen_q[0] & push;
   assign ev_tx = irqen_q[1] & tx_hs;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_INC;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_INC;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_INC;
         2'b01:   count_d = count_q - CNT_INC;
         default: count_d = count_q;
      endcase
   end

   // A fresh event in the clearing cycle wins over the clear
   always_comb begin
      rx_ovf_d  = ovf_ev | (rx_ovf_q & ~status_clr);
      tx_drop_d = tx_drop_ev | (tx_drop_q & ~status_clr);
   end

   always_comb begin
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      if (tx_load) begin
         tx_data_d  = port_out;
         tx_valid_d = 1'b1;
      end else if (tx_hs) begin
         tx_valid_d = 1'b0;
      end
   end

   always_comb begin
      irqen_d = irqen_q;
      if (write_strobe && (port_id == PORT_IRQEN)) begin
         irqen_d = port_out[1:0];
      end
      interrupt_d = ev_rx | ev_tx | (interrupt_q & ~interrupt_ack);
   end

   always_comb begin
      port_in_d = 8'h00;
      unique case (port_id)
         PORT_RXDATA:  port_in_d = head;
         PORT_STATUS:  port_in_d = {3'b000, tx_drop_q, tx_valid_q, rx_ovf_q, full, ~empty};
         PORT_IRQEN:   port_in_d = {6'b000000, irqen_q};
         PORT_RXCOUNT: port_in_d = {{(7 - FIFO_AW){1'b0}}, count_q};
         default:      port_in_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rx_ovf_q    <= 1'b0;
         tx_drop_q   <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         irqen_q     <= 2'b00;
         interrupt_q <= 1'b0;
         port_in_q   <= 8'h00;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rx_ovf_q    <= rx_ovf_d;
         tx_drop_q   <= tx_drop_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         irqen_q     <= irqen_d;
         interrupt_q <= interrupt_d;
         port_in_q   <= port_in_d;
      end
   end

   // Storage needs no reset: an empty FIFO never exposes its contents
   always_ff @(posedge clk) begin
      if (reset && push) begin
         mem[wr_ptr_q] <= rx_data;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign interrupt = interrupt_q;
   assign port_in   = port_in_q;

endmodule
